// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch bus responder: grants req/gnt address phases, reads a 1-cycle
// synchronous RAM and returns in-order rvalid/rdata/err through a small response FIFO.
module ibex_instr_mem_responder #(
  parameter logic [31:0] AddrBase       = 32'h0000_0000,
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        gnt_stall_i,
  input  logic                        rsp_hold_i,
  output logic                        ram_req_o,
  output logic [$clog2(MemWords)-1:0] ram_addr_o,
  input  logic [31:0]                 ram_rdata_i,
  output logic                        busy_o
);

  localparam int unsigned   AW       = $clog2(MemWords);
  localparam int unsigned   CW       = $clog2(MaxOutstanding + 1);
  localparam int unsigned   PW       = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [32:0]   WinBytes = 33'(MemWords) << 2;
  localparam logic [CW-1:0] MaxOut   = CW'(MaxOutstanding);
  localparam logic [PW-1:0] LastIdx  = PW'(MaxOutstanding - 1);

  logic [CW-1:0] r_outstanding;
  logic          r_vld_p1;
  logic          r_err_p1;
  logic [31:0]   r_fifo_data [MaxOutstanding];
  logic          r_fifo_err  [MaxOutstanding];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [31:0]   w_offset;
  logic          w_in_range;
  logic          w_misaligned;
  logic          w_err;
  logic          w_gnt;
  logic [31:0]   w_data_p1;
  logic          w_fifo_ne;
  logic          w_cand_vld;
  logic          w_cand_err;
  logic [31:0]   w_cand_data;
  logic          w_rvalid;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == LastIdx) ? '0 : ptr + PW'(1);
  endfunction

  // ---- stage p0: address phase, range check, RAM read issue ----
  // Unsigned subtract makes addresses below the window wrap to huge offsets.
  assign w_offset     = instr_addr_i - AddrBase;
  assign w_in_range   = {1'b0, w_offset} < WinBytes;
  assign w_misaligned = |instr_addr_i[1:0];
  assign w_err        = ~w_in_range | w_misaligned;

  assign w_gnt       = instr_req_i & ~gnt_stall_i & (r_outstanding < MaxOut) & ~rst_i;
  assign instr_gnt_o = w_gnt;
  assign ram_req_o   = w_gnt & ~w_err;
  assign ram_addr_o  = w_offset[AW+1:2];

  // ---- stage p1: RAM data returns, pick oldest response ----
  assign w_data_p1 = r_err_p1 ? 32'h0 : ram_rdata_i;

  assign w_fifo_ne   = (r_count != '0);
  assign w_cand_vld  = w_fifo_ne | r_vld_p1;
  assign w_cand_data = w_fifo_ne ? r_fifo_data[r_rd_ptr] : w_data_p1;
  assign w_cand_err  = w_fifo_ne ? r_fifo_err[r_rd_ptr]  : r_err_p1;
  assign w_rvalid    = w_cand_vld & ~rsp_hold_i;

  // Pending data must be parked whenever it cannot leave this cycle.
  assign w_push = r_vld_p1 & (w_fifo_ne | rsp_hold_i);
  assign w_pop  = w_fifo_ne & ~rsp_hold_i;

  assign instr_rvalid_o = w_rvalid;
  assign instr_rdata_o  = w_rvalid ? w_cand_data : 32'h0;
  assign instr_err_o    = w_rvalid & w_cand_err;
  assign busy_o         = (r_outstanding != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1      <= 1'b0;
      r_outstanding <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_vld_p1 <= w_gnt;
      case ({w_gnt, w_rvalid})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_gnt) r_err_p1 <= w_err;
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_data_p1;
      r_fifo_err[r_wr_ptr]  <= r_err_p1;
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && (r_count == MaxOut)));

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Cycle-table bench for ibex_instr_mem_responder with a RAM model, a FIFO-wrap
// stream and a second instance using a high base address.
module tb_ibex_instr_mem_responder;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, stall, hold;
  logic [31:0] addr;
  logic        gnt, rvalid, err, ram_req, busy;
  logic [31:0] rdata, ram_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] mem [1024];

  logic        b_req, b_stall, b_hold;
  logic [31:0] b_addr;
  logic        b_gnt, b_rvalid, b_err, b_ram_req, b_busy;
  logic [31:0] b_rdata, b_ram_rdata;
  logic [9:0]  b_ram_addr;

  int tests = 0;
  int fails = 0;
  int issued, got, cyc;

  ibex_instr_mem_responder dut (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata),
    .instr_err_o(err), .gnt_stall_i(stall), .rsp_hold_i(hold),
    .ram_req_o(ram_req), .ram_addr_o(ram_addr), .ram_rdata_i(ram_rdata),
    .busy_o(busy)
  );

  ibex_instr_mem_responder #(.AddrBase(32'h8000_0000)) dut_b (
    .clk_i(clk), .rst_i(rst), .instr_req_i(b_req), .instr_addr_i(b_addr),
    .instr_gnt_o(b_gnt), .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata),
    .instr_err_o(b_err), .gnt_stall_i(b_stall), .rsp_hold_i(b_hold),
    .ram_req_o(b_ram_req), .ram_addr_o(b_ram_addr), .ram_rdata_i(b_ram_rdata),
    .busy_o(b_busy)
  );

  always @(posedge clk) if (ram_req) ram_rdata <= mem[ram_addr];

  typedef struct {
    logic        rst, req;
    logic [31:0] addr;
    logic        stall, hold;
    logic        gnt, rreq;
    logic [9:0]  raddr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err, busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic q, input logic [31:0] a,
                              input logic s, input logic h, input logic g,
                              input logic rr, input logic [9:0] ra, input logic rv,
                              input logic [31:0] rd, input logic e, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.stall = s; v.hold = h;
    v.gnt = g; v.rreq = rr; v.raddr = ra; v.rvalid = rv; v.rdata = rd;
    v.err = e; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic ok, input string act, input string req_s);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %s, expected %s", name, act, req_s);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
    for (int i = 0; i < 4; i++) mem[i] = 32'h100 + 32'(i);
    mem[4] = 32'hDEAD_BEEF;
    ram_rdata = 32'h0;
    b_ram_rdata = 32'h1234_5678;
    rst = 1'b1; req = 1'b0; addr = 32'h0; stall = 1'b0; hold = 1'b0;
    b_req = 1'b0; b_addr = 32'h0; b_stall = 1'b0; b_hold = 1'b0;

    // reset state
    vecs.push_back(mk(H,H,32'h10,L,L, L,L,10'd0,L,32'h0,L,L));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,L,32'h0,L,L));
    // single fetch
    vecs.push_back(mk(L,H,32'h10,L,L, H,H,10'd4,L,32'h0,L,L));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,H,32'hDEAD_BEEF,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,L,32'h0,L,L));
    // back-to-back streaming
    vecs.push_back(mk(L,H,32'h0, L,L, H,H,10'd0,L,32'h0,L,L));
    vecs.push_back(mk(L,H,32'h4, L,L, H,H,10'd1,H,32'h100,L,H));
    vecs.push_back(mk(L,H,32'h8, L,L, H,H,10'd2,H,32'h101,L,H));
    vecs.push_back(mk(L,H,32'hC, L,L, H,H,10'd3,H,32'h102,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,H,32'h103,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,L,32'h0,L,L));
    // outstanding limit under response hold
    vecs.push_back(mk(L,H,32'h0, L,H, H,H,10'd0,L,32'h0,L,L));
    vecs.push_back(mk(L,H,32'h4, L,H, H,H,10'd1,L,32'h0,L,H));
    vecs.push_back(mk(L,H,32'h8, L,H, L,L,10'd0,L,32'h0,L,H));
    vecs.push_back(mk(L,H,32'h8, L,L, L,L,10'd0,H,32'h100,L,H));
    vecs.push_back(mk(L,H,32'h8, L,L, H,H,10'd2,H,32'h101,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,H,32'h102,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,L,32'h0,L,L));
    // errors: out of range, misaligned, wrap below base, last valid word
    vecs.push_back(mk(L,H,32'h1000,L,L, H,L,10'd0,L,32'h0,L,L));
    vecs.push_back(mk(L,H,32'h6,   L,L, H,L,10'd0,H,32'h0,H,H));
    vecs.push_back(mk(L,H,32'hFFFF_FFFC,L,L, H,L,10'd0,H,32'h0,H,H));
    vecs.push_back(mk(L,H,32'hFFC, L,L, H,H,10'd1023,H,32'h0,H,H));
    vecs.push_back(mk(L,L,32'h0,   L,L, L,L,10'd0,H,32'hA500_03FF,L,H));
    vecs.push_back(mk(L,L,32'h0,   L,L, L,L,10'd0,L,32'h0,L,L));
    // grant stall blocks grant only
    vecs.push_back(mk(L,H,32'h10,H,L, L,L,10'd0,L,32'h0,L,L));
    vecs.push_back(mk(L,H,32'h10,L,L, H,H,10'd4,L,32'h0,L,L));
    vecs.push_back(mk(L,H,32'h10,H,L, L,L,10'd0,H,32'hDEAD_BEEF,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,L,32'h0,L,L));
    // ordering through the FIFO: held first response, second grant meanwhile
    vecs.push_back(mk(L,H,32'h0, L,L, H,H,10'd0,L,32'h0,L,L));
    vecs.push_back(mk(L,H,32'h4, L,H, H,H,10'd1,L,32'h0,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,H,32'h100,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,H,32'h101,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,L,32'h0,L,L));
    // reset with two requests outstanding
    vecs.push_back(mk(L,H,32'h0, L,H, H,H,10'd0,L,32'h0,L,L));
    vecs.push_back(mk(L,H,32'h4, L,H, H,H,10'd1,L,32'h0,L,H));
    vecs.push_back(mk(H,L,32'h0, L,H, L,L,10'd0,L,32'h0,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,L,32'h0,L,L));
    vecs.push_back(mk(L,H,32'h10,L,L, H,H,10'd4,L,32'h0,L,L));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,H,32'hDEAD_BEEF,L,H));
    vecs.push_back(mk(L,L,32'h0, L,L, L,L,10'd0,L,32'h0,L,L));

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; addr = vecs[i].addr;
      stall = vecs[i].stall; hold = vecs[i].hold;
      @(negedge clk);
      check($sformatf("row%0d", i),
            (gnt === vecs[i].gnt) && (ram_req === vecs[i].rreq) &&
            (!vecs[i].rreq || ram_addr === vecs[i].raddr) &&
            (rvalid === vecs[i].rvalid) && (rdata === vecs[i].rdata) &&
            (err === vecs[i].err) && (busy === vecs[i].busy),
            $sformatf("gnt=%b rreq=%b raddr=%0d rv=%b rdata=%h err=%b busy=%b",
                      gnt, ram_req, ram_addr, rvalid, rdata, err, busy),
            $sformatf("gnt=%b rreq=%b raddr=%0d rv=%b rdata=%h err=%b busy=%b",
                      vecs[i].gnt, vecs[i].rreq, vecs[i].raddr, vecs[i].rvalid,
                      vecs[i].rdata, vecs[i].err, vecs[i].busy));
      @(posedge clk);
      #1;
    end

    // ten streamed requests under alternating hold, pointers wrap repeatedly
    rst = 1'b0; stall = 1'b0;
    issued = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 200) begin
      req  = (issued < 10);
      addr = 32'h40 + 32'(4 * issued);
      hold = (cyc % 2 == 1);
      @(negedge clk);
      if (rvalid) begin
        check($sformatf("wrap_rsp%0d", got),
              (rdata === 32'hA500_0010 + 32'(got)) && (err === 1'b0),
              $sformatf("rdata=%h err=%b", rdata, err),
              $sformatf("rdata=%h err=0", 32'hA500_0010 + 32'(got)));
        got++;
      end
      if (gnt) issued++;
      @(posedge clk);
      #1;
      cyc++;
    end
    req = 1'b0; hold = 1'b0;
    check("wrap_count", got == 10, $sformatf("%0d responses", got), "10 responses");
    @(negedge clk);
    check("wrap_idle", (busy === 1'b0) && (rvalid === 1'b0),
          $sformatf("busy=%b rv=%b", busy, rvalid), "busy=0 rv=0");
    @(posedge clk);
    #1;

    // high base address window
    b_req = 1'b1; b_addr = 32'h7FFF_FFFC;
    @(negedge clk);
    check("base_below_gnt", (b_gnt === 1'b1) && (b_ram_req === 1'b0),
          $sformatf("gnt=%b rreq=%b", b_gnt, b_ram_req), "gnt=1 rreq=0");
    @(posedge clk);
    #1;
    b_addr = 32'h8000_0010;
    @(negedge clk);
    check("base_below_rsp", (b_rvalid === 1'b1) && (b_err === 1'b1) && (b_rdata === 32'h0),
          $sformatf("rv=%b err=%b rdata=%h", b_rvalid, b_err, b_rdata), "rv=1 err=1 rdata=0");
    check("base_in_req", (b_gnt === 1'b1) && (b_ram_req === 1'b1) && (b_ram_addr === 10'd4),
          $sformatf("gnt=%b rreq=%b raddr=%0d", b_gnt, b_ram_req, b_ram_addr),
          "gnt=1 rreq=1 raddr=4");
    @(posedge clk);
    #1;
    b_req = 1'b0;
    @(negedge clk);
    check("base_in_rsp", (b_rvalid === 1'b1) && (b_err === 1'b0) && (b_rdata === 32'h1234_5678),
          $sformatf("rv=%b err=%b rdata=%h", b_rvalid, b_err, b_rdata),
          "rv=1 err=0 rdata=12345678");
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
